vga_fb_arbiter: RTL and testbench

//  Shares one single-port, 1-cycle-latency tile RAM (one byte per 8x8 cell) between
//  the VGA scan-out and two clients: a write port and a read port for the pixel logic.

---
 rtl/vga_fb_arbiter.sv | 135 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shares one 1-cycle tile RAM between VGA scan-out and a write/read client pair
// Display fetches sit on fixed pixel phases; clients fill the remaining cycles round-robin.
module vga_fb_arbiter #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 13,
   parameter int COLS      = 80,
   parameter int ROWS      = 60,
   parameter int H_PRELOAD = 792,
   parameter int V_TOTAL   = 525
) (
   input  logic              clk_25mhz,
   input  logic              rst,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   output logic [DATA_W-1:0] cell_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] CELLS  = ADDR_W'(COLS * ROWS);
   localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
   localparam logic [9:0]        V_ACT  = 10'(ROWS * 8);
   localparam logic [9:0]        V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]        H_PRE  = 10'(H_PRELOAD);

   typedef enum logic [1:0] {ST_IDLE, ST_DISP, ST_WR, ST_RD} state_t;
   state_t state, state_nx;

   logic              last_rd;
   logic              rd_hit;
   logic              rd_live;
   logic              disp_q;
   logic [DATA_W-1:0] prefetch;
   logic [9:0]        ny;
   logic [ADDR_W-1:0] col;
   logic [ADDR_W-1:0] disp_addr;
   logic              act_due;
   logic              pre_due;
   logic              wr_elig;
   logic              rd_elig;

   // Row base address: constant COLS folded into a sum of shifted copies of the row.
   function automatic logic [ADDR_W-1:0] mul_cols(input logic [ADDR_W-1:0] row);
      logic [ADDR_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < ADDR_W; i++)
         if (COLS_A[i]) acc = acc + (row << i);
      return acc;
   endfunction

   always_comb begin
      col       = ADDR_W'(pixel_x[9:3]);
      ny        = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
      act_due   = (pixel_y < V_ACT) && (pixel_x[2:0] == 3'd0) && ((col + ONE_A) < COLS_A);
      pre_due   = (pixel_x == H_PRE) && (ny < V_ACT);
      disp_addr = act_due ? mul_cols(ADDR_W'(pixel_y[9:3])) + col + ONE_A
                          : mul_cols(ADDR_W'(ny[9:3]));
   end

   always_ff @(posedge clk_25mhz or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   // A read stays outstanding through its rd_valid cycle so a still-high req is not served twice.
   always_comb begin
      wr_elig = wr_req && !wr_ack;
      rd_elig = rd_req && (state != ST_RD) && !rd_valid;
      if (act_due || pre_due)                 state_nx = ST_DISP;
      else if (wr_elig && (last_rd || !rd_elig)) state_nx = ST_WR;
      else if (rd_elig)                       state_nx = ST_RD;
      else                                    state_nx = ST_IDLE;
   end

   always_comb begin
      wr_ack  = (state == ST_WR);
      rd_data = rd_live ? mem_rdata : '0;
   end

   always_ff @(posedge clk_25mhz or negedge rst) begin
      if (!rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         last_rd   <= 1'b1;
         rd_hit    <= 1'b0;
         rd_live   <= 1'b0;
         rd_valid  <= 1'b0;
         disp_q    <= 1'b0;
         prefetch  <= '0;
         cell_data <= '0;
      end else begin
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         rd_hit <= 1'b0;
         case (state_nx)
            ST_DISP: begin
               mem_en   <= 1'b1;
               mem_addr <= disp_addr;
            end
            ST_WR: begin
               mem_en    <= (wr_addr < CELLS);
               mem_we    <= (wr_addr < CELLS);
               mem_addr  <= wr_addr;
               mem_wdata <= wr_data;
               last_rd   <= 1'b0;
            end
            ST_RD: begin
               mem_en   <= (rd_addr < CELLS);
               mem_addr <= rd_addr;
               rd_hit   <= (rd_addr < CELLS);
               last_rd  <= 1'b1;
            end
            default: ;
         endcase
         rd_valid <= (state == ST_RD);
         rd_live  <= rd_hit;
         disp_q   <= (state == ST_DISP);
         if (disp_q) prefetch <= mem_rdata;
         if (pixel_x[2:0] == 3'd7) cell_data <= prefetch;
      end
   end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed vector bench for vga_fb_arbiter with a 1-cycle RAM model
module tb_vga_fb_arbiter;
   logic        clk_25mhz = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  pixel_x = 10'd641;
   logic [9:0]  pixel_y = 10'd500;
   logic [7:0]  cell_data;
   logic        wr_req = 1'b0;
   logic [12:0] wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        wr_ack;
   logic        rd_req = 1'b0;
   logic [12:0] rd_addr = '0;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        mem_en;
   logic        mem_we;
   logic [12:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;
   logic        bd_we = 1'b0;
   logic [12:0] bd_addr = '0;
   logic [7:0]  bd_data = '0;
   logic [7:0]  ram [0:8191];
   int          n_checks = 0;
   int          n_fail = 0;
   int          code;
   int          prev;

   typedef struct {
      int   x;
      int   y;
      logic en;
      int   addr;
   } vec_t;
   vec_t vecs [15];
   int   exp_g [12];

   vga_fb_arbiter dut (
      .clk_25mhz(clk_25mhz), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .cell_data(cell_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   always @(posedge clk_25mhz) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
   end

   task automatic clk_at(input int x, input int y);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      @(posedge clk_25mhz);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic poke(input int a, input logic [7:0] d);
      bd_addr = 13'(a);
      bd_data = d;
      bd_we   = 1'b1;
      clk_at(641, 500);
      bd_we   = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{x:0,   y:0,   en:1'b1, addr:1};
      vecs[1]  = '{x:8,   y:0,   en:1'b1, addr:2};
      vecs[2]  = '{x:624, y:0,   en:1'b1, addr:79};
      vecs[3]  = '{x:632, y:0,   en:1'b0, addr:0};
      vecs[4]  = '{x:3,   y:0,   en:1'b0, addr:0};
      vecs[5]  = '{x:16,  y:479, en:1'b1, addr:4723};
      vecs[6]  = '{x:16,  y:480, en:1'b0, addr:0};
      vecs[7]  = '{x:40,  y:17,  en:1'b1, addr:166};
      vecs[8]  = '{x:792, y:9,   en:1'b1, addr:80};
      vecs[9]  = '{x:792, y:524, en:1'b1, addr:0};
      vecs[10] = '{x:792, y:479, en:1'b0, addr:0};
      vecs[11] = '{x:792, y:523, en:1'b0, addr:0};
      vecs[12] = '{x:792, y:478, en:1'b1, addr:4720};
      vecs[13] = '{x:792, y:0,   en:1'b1, addr:0};
      vecs[14] = '{x:792, y:7,   en:1'b1, addr:80};
      exp_g = '{1, 2, 1, 0, 2, 1, 0, 2, 1, 0, 2, 1};

      // reset held for three clocks, then released
      clk_at(641, 500);
      clk_at(641, 500);
      clk_at(641, 500);
      check("rst_hold_mem_en", mem_en, 0);
      check("rst_hold_cell_data", cell_data, 0);
      rst = 1'b1;
      clk_at(641, 500);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_wr_ack", wr_ack, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_cell_data", cell_data, 0);

      poke(80, 8'hA5);
      poke(9, 8'h5A);

      for (int i = 0; i < 15; i++) begin
         clk_at(vecs[i].x, vecs[i].y);
         check($sformatf("disp_en[%0d]", i), mem_en, vecs[i].en);
         check($sformatf("disp_we[%0d]", i), mem_we, 0);
         if (vecs[i].en) check($sformatf("disp_addr[%0d]", i), mem_addr, vecs[i].addr);
         clk_at(641, 500);
      end

      // preload of line 10 and its hand-off to cell_data at x=799
      clk_at(792, 9);
      check("pre_en", mem_en, 1);
      check("pre_addr", mem_addr, 80);
      for (int x = 793; x <= 798; x++) clk_at(x, 9);
      check("pre_cell_early", cell_data, 0);
      clk_at(799, 9);
      check("pre_cell", cell_data, 8'hA5);
      clk_at(641, 500);

      // write colliding with a display slot
      wr_addr = 13'd5;
      wr_data = 8'h3C;
      wr_req  = 1'b1;
      clk_at(8, 0);
      check("col_disp_en", mem_en, 1);
      check("col_disp_we", mem_we, 0);
      check("col_disp_addr", mem_addr, 2);
      check("col_disp_ack", wr_ack, 0);
      clk_at(9, 0);
      check("col_wr_en", mem_en, 1);
      check("col_wr_we", mem_we, 1);
      check("col_wr_addr", mem_addr, 5);
      check("col_wr_data", mem_wdata, 8'h3C);
      check("col_wr_ack", wr_ack, 1);
      clk_at(10, 0);
      check("col_ack_pulse", wr_ack, 0);
      check("col_no_regrant", mem_en, 0);
      wr_req = 1'b0;
      clk_at(11, 0);
      check("col_ack_low", wr_ack, 0);
      check("col_ram5", ram[5], 8'h3C);
      clk_at(641, 500);

      // both clients held; reset dropped mid-read, then service resumes
      wr_addr = 13'd7;
      wr_data = 8'h11;
      rd_addr = 13'd9;
      wr_req  = 1'b1;
      rd_req  = 1'b1;
      clk_at(641, 500);
      check("pre_rst_rd_grant", mem_en && !mem_we, 1);
      rst = 1'b0;
      #1;
      check("async_rst_en", mem_en, 0);
      clk_at(641, 500);
      rst  = 1'b1;
      prev = 0;
      for (int i = 0; i < 12; i++) begin
         clk_at(641, 500);
         code = mem_en ? (mem_we ? 1 : 2) : 0;
         check($sformatf("rr_grant[%0d]", i), code, exp_g[i]);
         check($sformatf("rr_wr_ack[%0d]", i), wr_ack, exp_g[i] == 1);
         check($sformatf("rr_rd_valid[%0d]", i), rd_valid, prev == 2);
         if (prev == 2) check($sformatf("rr_rd_data[%0d]", i), rd_data, 8'h5A);
         prev = exp_g[i];
      end
      wr_req = 1'b0;
      rd_req = 1'b0;
      clk_at(641, 500);
      clk_at(641, 500);

      // out-of-range accesses
      wr_addr = 13'd4800;
      wr_data = 8'hFF;
      wr_req  = 1'b1;
      clk_at(641, 500);
      check("oor_wr_ack", wr_ack, 1);
      check("oor_wr_en", mem_en, 0);
      clk_at(641, 500);
      check("oor_wr_ack_pulse", wr_ack, 0);
      wr_req  = 1'b0;
      rd_addr = 13'd4800;
      rd_req  = 1'b1;
      clk_at(641, 500);
      check("oor_rd_en", mem_en, 0);
      check("oor_rd_valid_early", rd_valid, 0);
      clk_at(641, 500);
      check("oor_rd_valid", rd_valid, 1);
      check("oor_rd_data", rd_data, 0);
      rd_req = 1'b0;
      clk_at(641, 500);
      check("oor_rd_valid_pulse", rd_valid, 0);
      check("oor_rd_no_regrant", mem_en, 0);

      // vertical blanking: no preload from line 479 through 523, no active fetches
      for (int y = 479; y <= 523; y++) begin
         clk_at(792, y);
         check($sformatf("vblank_pre[%0d]", y), mem_en, 0);
      end
      clk_at(16, 500);
      check("vblank_act", mem_en, 0);
      clk_at(792, 524);
      check("wrap_en", mem_en, 1);
      check("wrap_addr", mem_addr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
